// File: rtl/hyperram_controller_pkg.sv
// Shared types and constants for the HyperRAM controller.
// Holds the FSM states, the command/address bit map and the fixed phase lengths.
package hyperram_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        WRITE,
        READ,
        DONE,
        RECOVER
    } state_t;

    localparam int CA_RW_BIT      = 47;
    localparam int CA_AS_BIT      = 46;
    localparam int CA_BURST_BIT   = 45;
    localparam int CA_ROW_MSB     = 44;
    localparam int CA_ROW_LSB     = 16;
    localparam int CA_COL_BITS    = 3;
    localparam int CA_BYTES       = 6;
    localparam int DATA_BYTES     = 4;
    localparam int RECOVER_CYCLES = 4;
    localparam int TIMEOUT_EXTRA  = 16;

    function automatic logic [47:0] hyperbus_ca_builder(input logic is_read, input logic [31:0] ha);
        logic [47:0] ca;
        ca                            = '0;
        ca[CA_RW_BIT]                 = is_read;
        ca[CA_AS_BIT]                 = 1'b0;
        ca[CA_BURST_BIT]              = 1'b1;
        ca[CA_ROW_MSB:CA_ROW_LSB]     = ha[31:CA_COL_BITS];
        ca[CA_COL_BITS-1:0]           = ha[CA_COL_BITS-1:0];
        return ca;
    endfunction

    // Bytes travel as two big-endian halfwords, low halfword first: lanes 1,0,3,2.
    function automatic logic [1:0] byte_lane(input logic [1:0] idx);
        return {idx[1], ~idx[0]};
    endfunction

endpackage

// File: rtl/hyperram_controller.sv
// CPU 32-bit word bus to 8-bit DDR HyperRAM bridge: one request becomes one
// HyperBus transaction (command/address, initial latency, four data bytes).
module hyperram_controller
    import hyperram_controller_pkg::*;
#(
    parameter int LATENCY     = 6,
    parameter int MEMORY_BITS = 21
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [MEMORY_BITS-1:0] cpu_address,
    input  logic [31:0]            cpu_data_in,
    output logic [31:0]            cpu_data_out,
    input  logic                   cpu_req,
    output logic                   cpu_ack,
    input  logic [3:0]             cpu_nwr,
    output logic                   hyperram_ncs,
    output logic                   hyperram_nreset,
    output logic                   hyperram_clk,
    input  logic                   hyperram_rwds_in,
    output logic                   hyperram_rwds_out,
    output logic                   hyperram_rwds_noe,
    input  logic [7:0]             hyperram_data_in,
    output logic [7:0]             hyperram_data_out,
    output logic                   hyperram_data_noe
);

    state_t                 state_reg, state_next;
    logic [7:0]             cyc_reg, cyc_next;
    logic                   lat_x2_reg, read_reg, rwds_reg;
    logic [MEMORY_BITS-1:0] addr_reg;
    logic [31:0]            wdata_reg, rd_data_reg, rd_data_next;
    logic [3:0]             nwr_reg;
    logic [2:0]             cap_cnt_reg, cap_cnt_next;
    logic [1:0]             rd_lane, wr_lane;
    logic [7:0]             n_lat, lat_end, wr_end, rd_end, data_start;
    logic [47:0]            ca_word;
    logic [31:0]            ha;
    logic                   ncs_next, ck_next, data_noe_next, rwds_noe_next, rwds_out_next, ack_next;
    logic [7:0]             dq_next;
    logic [31:0]            cpu_data_next;

    // Phase boundaries as cycle indices counted from the first chip-select cycle.
    assign n_lat      = lat_x2_reg ? 8'(2 * LATENCY) : 8'(LATENCY);
    assign lat_end    = (n_lat << 1) + 8'd1;
    assign data_start = (n_lat << 1) + 8'd2;
    assign wr_end     = (n_lat << 1) + 8'd5;
    assign rd_end     = (n_lat << 2) + 8'(TIMEOUT_EXTRA + 1);

    // Before acceptance the command must come straight from the bus, afterwards from the latches.
    assign ha      = 32'({(state_reg == IDLE) ? cpu_address : addr_reg, 1'b0});
    assign ca_word = hyperbus_ca_builder((state_reg == IDLE) ? (&cpu_nwr) : read_reg, ha);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg         <= IDLE;
            cyc_reg           <= '0;
            lat_x2_reg        <= 1'b0;
            read_reg          <= 1'b0;
            addr_reg          <= '0;
            wdata_reg         <= '0;
            nwr_reg           <= '1;
            rwds_reg          <= 1'b0;
            cap_cnt_reg       <= '0;
            rd_data_reg       <= '0;
            hyperram_ncs      <= 1'b1;
            hyperram_nreset   <= 1'b0;
            hyperram_clk      <= 1'b0;
            hyperram_data_noe <= 1'b1;
            hyperram_rwds_noe <= 1'b1;
            hyperram_data_out <= '0;
            hyperram_rwds_out <= 1'b0;
            cpu_ack           <= 1'b0;
            cpu_data_out      <= '0;
        end else begin
            state_reg         <= state_next;
            cyc_reg           <= cyc_next;
            rwds_reg          <= hyperram_rwds_in;
            cap_cnt_reg       <= cap_cnt_next;
            rd_data_reg       <= rd_data_next;
            hyperram_nreset   <= 1'b1;
            hyperram_ncs      <= ncs_next;
            hyperram_clk      <= ck_next;
            hyperram_data_noe <= data_noe_next;
            hyperram_rwds_noe <= rwds_noe_next;
            hyperram_data_out <= dq_next;
            hyperram_rwds_out <= rwds_out_next;
            cpu_ack           <= ack_next;
            cpu_data_out      <= cpu_data_next;
            if (state_reg == IDLE && state_next == CA) begin
                addr_reg  <= cpu_address;
                wdata_reg <= cpu_data_in;
                nwr_reg   <= cpu_nwr;
                read_reg  <= &cpu_nwr;
            end
            if (state_reg == CA && cyc_reg == 8'd2)
                lat_x2_reg <= hyperram_rwds_in;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg + 8'd1;
        rd_data_next = rd_data_reg;
        cap_cnt_next = cap_cnt_reg;
        rd_lane      = byte_lane(cap_cnt_reg[1:0]);
        if (state_reg == LAT) begin
            rd_data_next = '0;
            cap_cnt_next = '0;
        end else if (state_reg == READ && hyperram_rwds_in != rwds_reg
                     && cap_cnt_reg < 3'(DATA_BYTES)) begin
            rd_data_next[{rd_lane, 3'b000} +: 8] = hyperram_data_in;
            cap_cnt_next = cap_cnt_reg + 3'd1;
        end
        case (state_reg)
            IDLE: begin
                cyc_next = '0;
                if (cpu_req && !cpu_ack) state_next = CA;
            end
            CA:      if (cyc_reg == 8'(CA_BYTES - 1)) state_next = LAT;
            LAT:     if (cyc_reg == lat_end) state_next = read_reg ? READ : WRITE;
            WRITE:   if (cyc_reg == wr_end) state_next = DONE;
            READ:    if (cap_cnt_next == 3'(DATA_BYTES) || cyc_reg == rd_end) state_next = DONE;
            DONE: begin
                cyc_next = '0;
                if (!cpu_req) state_next = RECOVER;
            end
            RECOVER: if (cyc_reg == 8'(RECOVER_CYCLES - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pad values are decoded from the upcoming state so every output leaves a flop.
    always_comb begin
        ncs_next      = 1'b1;
        ck_next       = 1'b0;
        data_noe_next = 1'b1;
        rwds_noe_next = 1'b1;
        rwds_out_next = 1'b0;
        dq_next       = '0;
        ack_next      = (state_next == DONE);
        cpu_data_next = cpu_data_out;
        wr_lane       = byte_lane(2'(cyc_next - data_start));
        if (state_next == CA || state_next == LAT || state_next == WRITE || state_next == READ) begin
            ncs_next = 1'b0;
            ck_next  = (state_reg == IDLE) ? 1'b0 : ~hyperram_clk;
        end
        case (state_next)
            CA: begin
                data_noe_next = 1'b0;
                case (cyc_next[2:0])
                    3'd0:    dq_next = ca_word[47:40];
                    3'd1:    dq_next = ca_word[39:32];
                    3'd2:    dq_next = ca_word[31:24];
                    3'd3:    dq_next = ca_word[23:16];
                    3'd4:    dq_next = ca_word[15:8];
                    default: dq_next = ca_word[7:0];
                endcase
            end
            LAT:   data_noe_next = read_reg;
            WRITE: begin
                data_noe_next = 1'b0;
                rwds_noe_next = 1'b0;
                dq_next       = wdata_reg[{wr_lane, 3'b000} +: 8];
                rwds_out_next = nwr_reg[wr_lane];
            end
            default: ;
        endcase
        if (state_reg == READ && state_next == DONE)
            cpu_data_next = rd_data_next;
    end

endmodule

// File: tb/tb_hyperram_controller.sv
// Self-checking bench: a behavioural HyperRAM device plus a word-level scoreboard
// drive randomized CPU requests through hyperram_controller.
module tb_hyperram_controller;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [20:0] cpu_address = '0;
    logic [31:0] cpu_data_in = '0;
    logic [31:0] cpu_data_out;
    logic        cpu_req = 1'b0;
    logic        cpu_ack;
    logic [3:0]  cpu_nwr = 4'hF;
    logic        hyperram_ncs, hyperram_nreset, hyperram_clk;
    logic        hyperram_rwds_in = 1'b0;
    logic        hyperram_rwds_out, hyperram_rwds_noe;
    logic [7:0]  hyperram_data_in = '0;
    logic [7:0]  hyperram_data_out;
    logic        hyperram_data_noe;

    always #5 clk = ~clk;

    hyperram_controller #(.LATENCY(LAT), .MEMORY_BITS(21)) dut (
        .clk(clk), .nreset(nreset),
        .cpu_address(cpu_address), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
        .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_nwr(cpu_nwr),
        .hyperram_ncs(hyperram_ncs), .hyperram_nreset(hyperram_nreset), .hyperram_clk(hyperram_clk),
        .hyperram_rwds_in(hyperram_rwds_in), .hyperram_rwds_out(hyperram_rwds_out),
        .hyperram_rwds_noe(hyperram_rwds_noe), .hyperram_data_in(hyperram_data_in),
        .hyperram_data_out(hyperram_data_out), .hyperram_data_noe(hyperram_data_noe)
    );

    int checks = 0;
    int errors = 0;
    int high_run = 100;
    int txn_no = 0;
    logic [31:0] dev_mem [int];
    logic [31:0] ref_mem [int];
    int lane_ord [4] = '{1, 0, 3, 2};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dev_read(input int w);
        return dev_mem.exists(w) ? dev_mem[w] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_read(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (hyperram_ncs) high_run++;
    endtask

    task automatic run_txn(input logic [20:0] addr, input logic [31:0] wdata, input logic [3:0] nwr,
                           input bit lat2, input bit respond);
        bit          is_read;
        int          n, k, j, next_drv, first_w, wait_cnt, ck_err, dev_w;
        logic [47:0] ca_got, ca_exp;
        logic [31:0] ha, src, exp_rd, word;
        logic [7:0]  dq_q [$];
        logic        rw_q [$];
        logic [31:0] got_bytes;
        logic [3:0]  got_mask;
        is_read = (nwr == 4'hF);
        n       = lat2 ? 2 * LAT : LAT;
        ha      = {10'b0, addr, 1'b0};
        ca_exp  = (48'(is_read) << 47) | (48'd1 << 45) | (48'(ha >> 3) << 16) | 48'(ha & 32'd7);
        ca_got  = '0;
        src     = '0;
        ck_err  = 0;
        first_w = -1;
        hyperram_rwds_in = lat2;
        hyperram_data_in = '0;
        cpu_address = addr;
        cpu_data_in = wdata;
        cpu_nwr     = nwr;
        cpu_req     = 1'b1;
        wait_cnt    = 0;
        do begin
            tick();
            wait_cnt++;
        end while (hyperram_ncs && wait_cnt < 50);
        check("accept", hyperram_ncs, 0);
        check("recover", high_run >= 4, 1);
        // Bus changes after acceptance must not leak into the transaction.
        cpu_address = 21'($urandom);
        cpu_data_in = $urandom;
        cpu_nwr     = 4'($urandom);
        k = 0;
        j = 0;
        next_drv = 2 * n + 2 + $urandom_range(0, 2);
        while (!hyperram_ncs && k < 200) begin
            dq_q.push_back(hyperram_data_out);
            rw_q.push_back(hyperram_rwds_out);
            if (hyperram_clk !== 1'(k % 2)) ck_err++;
            if (first_w < 0 && !hyperram_rwds_noe) first_w = k;
            if (k < 6) ca_got = {ca_got[39:0], hyperram_data_out};
            if (k == 5) begin
                hyperram_rwds_in = 1'b0;
                dev_w = int'({ca_got[44:16], ca_got[2:0]} >> 1);
                src   = dev_read(dev_w);
            end
            if (is_read && k == 2 * n + 2) check("rd_noe", hyperram_data_noe, 1);
            if (is_read && respond && j < 4 && k == next_drv) begin
                hyperram_data_in = src[lane_ord[j] * 8 +: 8];
                hyperram_rwds_in = ~hyperram_rwds_in;
                j++;
                next_drv = k + 1 + $urandom_range(0, 2);
            end
            k++;
            @(negedge clk);
        end
        high_run = 1;
        check("ca", ca_got, ca_exp);
        check("ck", ck_err, 0);
        if (!is_read) begin
            check("wlen", k, 2 * n + 6);
            check("wstart", first_w, 2 * n + 2);
            if (dq_q.size() >= 2 * n + 6) begin
                got_bytes = {dq_q[2*n+2], dq_q[2*n+3], dq_q[2*n+4], dq_q[2*n+5]};
                got_mask  = {rw_q[2*n+2], rw_q[2*n+3], rw_q[2*n+4], rw_q[2*n+5]};
                check("wdata", got_bytes, {wdata[15:8], wdata[7:0], wdata[31:24], wdata[23:16]});
                check("wmask", got_mask, {nwr[1], nwr[0], nwr[3], nwr[2]});
                word = dev_read(int'({ca_got[44:16], ca_got[2:0]} >> 1));
                for (int b = 0; b < 4; b++)
                    if (!got_mask[3-b]) word[lane_ord[b]*8 +: 8] = got_bytes[(3-b)*8 +: 8];
                dev_mem[int'({ca_got[44:16], ca_got[2:0]} >> 1)] = word;
            end
            word = ref_read(int'(addr));
            for (int b = 0; b < 4; b++)
                if (!nwr[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
            ref_mem[int'(addr)] = word;
        end else if (!respond) begin
            check("timeout_len", k, 4 * n + 18);
        end
        wait_cnt = 0;
        while (!cpu_ack && wait_cnt < 100) begin
            tick();
            wait_cnt++;
        end
        check("ack", cpu_ack, 1);
        exp_rd = (is_read && respond) ? ref_read(int'(addr)) : 32'h0;
        if (is_read) check("rdata", cpu_data_out, exp_rd);
        $display("txn %0d: %s addr=%06h wdata=%08h nwr=%h lat2=%0d respond=%0d rdata=%08h cycles=%0d",
                 txn_no, is_read ? "RD" : "WR", addr, wdata, nwr, lat2, respond, cpu_data_out, k);
        txn_no++;
        cpu_req = 1'b0;
        tick();
        check("ack_drop", cpu_ack, 0);
    endtask

    initial begin
        int wait_cnt;
        bit rd;
        #12;
        check("rst_ncs", hyperram_ncs, 1);
        check("rst_ck", hyperram_clk, 0);
        check("rst_noe", {hyperram_data_noe, hyperram_rwds_noe}, 2'b11);
        check("rst_out", {hyperram_data_out, hyperram_rwds_out}, 9'h0);
        check("rst_ack", cpu_ack, 0);
        check("rst_rdata", cpu_data_out, 0);
        check("rst_dev", hyperram_nreset, 0);
        @(negedge clk);
        nreset = 1'b1;
        tick();
        check("dev_release", hyperram_nreset, 1);

        run_txn(21'h10, 32'h11223344, 4'h0, 1'b0, 1'b1);
        check("ca_example", 48'h2000_0004_0000,
              (48'd1 << 45) | (48'(32'h20 >> 3) << 16) | 48'(32'h20 & 32'd7));
        run_txn(21'h10, 32'h0, 4'hF, 1'b0, 1'b1);
        run_txn(21'h20, 32'hAABBCCDD, 4'b1110, 1'b0, 1'b1);
        run_txn(21'h20, 32'h0, 4'hF, 1'b0, 1'b1);
        check("byte_write", ref_read(32'h20), 32'h000000DD);
        run_txn(21'h10, 32'h0, 4'hF, 1'b1, 1'b1);
        run_txn(21'h30, 32'hCAFEF00D, 4'h0, 1'b1, 1'b1);
        run_txn(21'h10, 32'h0, 4'hF, 1'b0, 1'b0);
        run_txn(21'h30, 32'h0, 4'hF, 1'b0, 1'b1);

        // Reset in the middle of the write data phase.
        cpu_address = 21'h1FFFF0;
        cpu_data_in = 32'h5A5A5A5A;
        cpu_nwr     = 4'h0;
        hyperram_rwds_in = 1'b0;
        cpu_req     = 1'b1;
        wait_cnt    = 0;
        do begin
            tick();
            wait_cnt++;
        end while (hyperram_rwds_noe && wait_cnt < 60);
        check("midwr_reach", hyperram_rwds_noe, 0);
        nreset = 1'b0;
        #1;
        check("midwr_ncs", hyperram_ncs, 1);
        check("midwr_noe", {hyperram_data_noe, hyperram_rwds_noe}, 2'b11);
        check("midwr_ack", cpu_ack, 0);
        check("midwr_dev", hyperram_nreset, 0);
        check("midwr_ck", hyperram_clk, 0);
        cpu_req = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        tick();
        check("midwr_release", hyperram_nreset, 1);
        high_run = 100;
        run_txn(21'h10, 32'h0, 4'hF, 1'b0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            logic [20:0] a;
            a  = 21'($urandom_range(0, 7)) | (21'($urandom_range(0, 3)) << 19);
            rd = ($urandom_range(0, 1) == 1);
            if (rd)
                run_txn(a, $urandom, 4'hF, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
            else
                run_txn(a, $urandom, 4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
